// File: rtl/cache_dma_sequencer.sv
// Descriptor queue and dispatcher in front of the memory-to-cache connector.
// The CPU stages fields through a register port and pushes them; entries issue one at a time.
module cache_dma_sequencer #(
  parameter int DEPTH = 4,
  parameter int LW    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reg_wen,
  input  logic [2:0]  reg_addr,
  input  logic [15:0] reg_wdata,
  output logic [15:0] reg_rdata,
  output logic        irq,
  input  logic        is_running,
  output logic        start_operation,
  output logic        new_wren,
  output logic [21:0] new_mem_addr,
  output logic [15:0] new_cache_addr,
  output logic [15:0] new_count
);

  // state   | meaning
  // S_IDLE  | waiting for a queued descriptor and an idle connector
  // S_START | start pulse out, new_* hold the popped descriptor
  // S_WAIT  | connector busy; first idle cycle counts a completion
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  localparam int EW = 55;
  localparam logic [LW:0] FULL_LVL = DEPTH[LW:0];

  state_t state_q, state_d;

  logic [21:0]   mem_q;
  logic [15:0]   cache_q, count_q, done_q, done_d;
  logic [EW-1:0] fifo_q [DEPTH];
  logic [LW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW:0]   level_q, level_d;
  logic          ovf_q, pend_q, pend_d, irq_en_q;
  logic [15:0]   rdata_d;

  logic empty, full, pop, push_req, push_real, push_zero, push_ok, ovf_set, complete, busy;
  logic [1:0] done_inc;

  assign empty     = (level_q == '0);
  assign full      = (level_q == FULL_LVL);
  assign pop       = (state_q == S_IDLE) && !empty && !is_running;
  assign push_req  = reg_wen && (reg_addr == 3'd4);
  assign push_zero = push_req && (count_q == 16'd0);
  assign push_real = push_req && (count_q != 16'd0);
  assign push_ok   = push_real && (!full || pop);
  assign ovf_set   = push_real && full && !pop;
  assign complete  = (state_q == S_WAIT) && !is_running;
  assign busy      = !empty || (state_q != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (!is_running) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_operation = (state_q == S_START);
  end

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    done_inc = {1'b0, complete} + {1'b0, push_zero};
    done_d   = done_q + {14'd0, done_inc};
    // A completion outranks a same-cycle software clear.
    pend_d = pend_q;
    if (reg_wen && reg_addr == 3'd5 && reg_wdata[3]) pend_d = 1'b0;
    if (complete || push_zero)                        pend_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (push_ok) fifo_q[wr_ptr_q] <= {reg_wdata[0], mem_q, cache_q, count_q};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q          <= '0;
      cache_q        <= '0;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      ovf_q          <= 1'b0;
      pend_q         <= 1'b0;
      irq_en_q       <= 1'b0;
      done_q         <= '0;
      new_wren       <= 1'b0;
      new_mem_addr   <= '0;
      new_cache_addr <= '0;
      new_count      <= '0;
    end else begin
      if (reg_wen) begin
        case (reg_addr)
          3'd0: mem_q[15:0]  <= reg_wdata;
          3'd1: mem_q[21:16] <= reg_wdata[5:0];
          3'd2: cache_q      <= reg_wdata;
          3'd3: count_q      <= reg_wdata;
          3'd5: if (reg_wdata[2]) ovf_q <= 1'b0;
          3'd6: irq_en_q     <= reg_wdata[0];
          default: ;
        endcase
      end
      if (ovf_set) ovf_q <= 1'b1;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        {new_wren, new_mem_addr, new_cache_addr, new_count} <= fifo_q[rd_ptr_q];
      end
      level_q <= level_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (reg_addr)
      3'd0: rdata_d = mem_q[15:0];
      3'd1: rdata_d = {10'd0, mem_q[21:16]};
      3'd2: rdata_d = cache_q;
      3'd3: rdata_d = count_q;
      3'd4: rdata_d = 16'(level_q);
      3'd5: rdata_d = {12'd0, pend_q, ovf_q, full, busy};
      3'd6: rdata_d = {15'd0, irq_en_q};
      3'd7: rdata_d = done_q;
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) reg_rdata <= '0;
    else       reg_rdata <= rdata_d;
  end

  assign irq = irq_en_q & pend_q;

endmodule

// File: tb/tb_cache_dma_sequencer.sv
// Directed bench for cache_dma_sequencer: a queue scoreboard holds expected descriptors,
// a small connector model drives is_running, and status registers are checked by readback.
module tb_cache_dma_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reg_wen = 1'b0;
  logic [2:0]  reg_addr = '0;
  logic [15:0] reg_wdata = '0;
  logic [15:0] reg_rdata;
  logic        irq;
  logic        is_running;
  logic        start_operation;
  logic        new_wren;
  logic [21:0] new_mem_addr;
  logic [15:0] new_cache_addr;
  logic [15:0] new_count;

  cache_dma_sequencer #(.DEPTH(4), .LW(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .reg_wen         (reg_wen),
    .reg_addr        (reg_addr),
    .reg_wdata       (reg_wdata),
    .reg_rdata       (reg_rdata),
    .irq             (irq),
    .is_running      (is_running),
    .start_operation (start_operation),
    .new_wren        (new_wren),
    .new_mem_addr    (new_mem_addr),
    .new_cache_addr  (new_cache_addr),
    .new_count       (new_count)
  );

  always #5 clock = ~clock;

  // Connector model: busy during the start pulse and for run_len cycles after it.
  logic run_hold = 1'b0;
  int   run_len  = 10;
  int   run_cnt  = 0;
  assign is_running = run_hold | start_operation | (run_cnt != 0);

  always @(posedge clock) begin
    if (reset)                run_cnt <= 0;
    else if (start_operation) run_cnt <= run_len;
    else if (run_cnt > 0)     run_cnt <= run_cnt - 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [54:0] sb [$];
  int pulses = 0;
  int cyc = 0;
  int last_pulse = -100;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (start_operation) begin
      pulses++;
      chk("pulse_spacing", 64'(cyc - last_pulse >= 3), 64'd1);
      last_pulse = cyc;
      chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        logic [54:0] e;
        e = sb.pop_front();
        chk("descriptor", {new_wren, new_mem_addr, new_cache_addr, new_count}, e);
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clock);
    reg_wen = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clock);
    reg_wen = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] v);
    @(negedge clock);
    reg_wen = 1'b0; reg_addr = a;
    @(negedge clock);
    v = reg_rdata;
  endtask

  task automatic stage(input logic [21:0] m, input logic [15:0] c, input logic [15:0] n);
    wr(3'd0, m[15:0]);
    wr(3'd1, {10'd0, m[21:16]});
    wr(3'd2, c);
    wr(3'd3, n);
  endtask

  task automatic push(input logic w, input logic [21:0] m, input logic [15:0] c,
                      input logic [15:0] n, input logic accept);
    stage(m, c, n);
    if (accept && n != 16'd0) sb.push_back({w, m, c, n});
    wr(3'd4, {15'd0, w});
  endtask

  task automatic wait_idle();
    logic [15:0] s;
    s = 16'hFFFF;
    for (int k = 0; k < 200; k++) begin
      rd(3'd5, s);
      if (!s[0]) break;
    end
    chk("idle_timeout", {63'd0, s[0]}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int p0;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_start", {63'd0, start_operation}, 64'd0);
    chk("rst_new", {new_wren, new_mem_addr, new_cache_addr, new_count}, 64'd0);
    chk("rst_irq", {63'd0, irq}, 64'd0);
    chk("rst_rdata", {48'd0, reg_rdata}, 64'd0);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      chk("rst_reg", {48'd0, v}, 64'd0);
    end

    // Single descriptor, connector busy 10 cycles.
    run_len = 10;
    push(1'b1, 22'h3F1234, 16'h0040, 16'd8, 1'b1);
    wait_idle();
    chk("t1_pulses", 64'(pulses), 64'd1);
    rd(3'd7, v); chk("t1_done", {48'd0, v}, 64'd1);
    rd(3'd5, v); chk("t1_status", {48'd0, v}, 64'h0008);
    rd(3'd0, v); chk("t1_mem_lo", {48'd0, v}, 64'h1234);
    rd(3'd1, v); chk("t1_mem_hi", {48'd0, v}, 64'h003F);
    rd(3'd2, v); chk("t1_cache", {48'd0, v}, 64'h0040);
    rd(3'd3, v); chk("t1_count", {48'd0, v}, 64'd8);

    // Interrupt enable, set by completion, cleared by STATUS write.
    wr(3'd5, 16'h0008);
    chk("t2_irq_clr0", {63'd0, irq}, 64'd0);
    wr(3'd6, 16'h0001);
    rd(3'd6, v); chk("t2_irq_en", {48'd0, v}, 64'd1);
    chk("t2_irq_idle", {63'd0, irq}, 64'd0);
    push(1'b0, 22'h000100, 16'h0200, 16'd3, 1'b1);
    wait_idle();
    chk("t2_irq_set", {63'd0, irq}, 64'd1);
    wr(3'd5, 16'h0008);
    chk("t2_irq_clr", {63'd0, irq}, 64'd0);

    // Fill while the connector is busy, overflow on the fifth push.
    run_hold = 1'b1;
    for (int i = 0; i < 5; i++)
      push(i[0], 22'h010000 + 22'(i), 16'h1000 + 16'(i), 16'(i + 1), i < 4);
    rd(3'd4, v); chk("t3_level", {48'd0, v}, 64'd4);
    rd(3'd5, v); chk("t3_status", {48'd0, v}, 64'h0007);
    chk("t3_no_pulse", 64'(pulses), 64'd2);
    run_len = 2;
    @(negedge clock);
    run_hold = 1'b0;
    wait_idle();
    chk("t3_pulses", 64'(pulses), 64'd6);
    rd(3'd7, v); chk("t3_done", {48'd0, v}, 64'd6);
    rd(3'd5, v); chk("t3_ovf_sticky", {48'd0, v}, 64'h000C);
    wr(3'd5, 16'h0004);
    rd(3'd5, v); chk("t3_ovf_clr", {48'd0, v}, 64'h0008);

    // Zero-count push completes immediately without a pulse.
    wr(3'd5, 16'h0008);
    p0 = pulses;
    push(1'b0, 22'h002222, 16'h0033, 16'd0, 1'b1);
    repeat (5) @(negedge clock);
    chk("t4_no_pulse", 64'(pulses), 64'(p0));
    rd(3'd7, v); chk("t4_done", {48'd0, v}, 64'd7);
    rd(3'd5, v); chk("t4_status", {48'd0, v}, 64'h0008);

    // Push into a full FIFO in the same cycle as the IDLE pop.
    wr(3'd5, 16'h0008);
    p0 = pulses;
    run_hold = 1'b1;
    for (int i = 0; i < 4; i++)
      push(1'b1, 22'h200000 + 22'(i), 16'h2000 + 16'(i), 16'(i + 5), 1'b1);
    stage(22'h3ABCDE, 16'h7777, 16'd9);
    @(negedge clock);
    sb.push_back({1'b0, 22'h3ABCDE, 16'h7777, 16'd9});
    run_hold = 1'b0;
    reg_wen = 1'b1; reg_addr = 3'd4; reg_wdata = 16'h0000;
    @(negedge clock);
    reg_wen = 1'b0; reg_addr = 3'd4;
    @(negedge clock);
    chk("t5_level", {48'd0, reg_rdata}, 64'd4);
    wait_idle();
    chk("t5_pulses", 64'(pulses - p0), 64'd5);
    chk("t5_sb_drained", 64'(sb.size()), 64'd0);
    rd(3'd7, v); chk("t5_done", {48'd0, v}, 64'd12);
    rd(3'd5, v); chk("t5_status", {48'd0, v}, 64'h0008);

    // Reset during WAIT with two entries queued.
    wr(3'd5, 16'h0008);
    run_len = 80;
    for (int i = 0; i < 3; i++)
      push(1'b1, 22'h000500 + 22'(i), 16'h0500 + 16'(i), 16'd4, 1'b1);
    rd(3'd4, v); chk("t6_queued", {48'd0, v}, 64'd2);
    rd(3'd5, v); chk("t6_busy", {48'd0, v}, 64'h0001);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    p0 = pulses;
    chk("t6_new_rst", {new_wren, new_mem_addr, new_cache_addr, new_count}, 64'd0);
    rd(3'd5, v); chk("t6_status", {48'd0, v}, 64'd0);
    rd(3'd7, v); chk("t6_done", {48'd0, v}, 64'd0);
    rd(3'd4, v); chk("t6_level", {48'd0, v}, 64'd0);
    repeat (60) @(negedge clock);
    chk("t6_no_pulse", 64'(pulses), 64'(p0));
    chk("t6_irq", {63'd0, irq}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
